// File: rtl/imem_ctrl_pkg.sv
// Shared types for the instruction-memory responder.
// Request/response bundles, FSM state, and register image.
package imem_ctrl_pkg;

  localparam int CNT_W = 4;

  typedef struct packed {
    logic        valid;
    logic        fence;
    logic        spec;
    logic        instr;
    logic [31:0] addr;
    logic [3:0]  wstrb;
  } mem_in_type;

  typedef struct packed {
    logic [31:0] mem_rdata;
    logic        mem_error;
    logic        mem_ready;
  } mem_out_type;

  typedef enum logic [1:0] {
    IDLE, READ, DRAIN, FLUSH
  } imem_ctrl_state_type;

  typedef enum logic [2:0] {
    P_NONE, P_READ, P_ERR, P_FENCE, P_ABORT
  } pend_type;

  typedef struct packed {
    imem_ctrl_state_type state;
    logic [CNT_W-1:0]    cnt;
    pend_type            pend;
    logic                ram_en;
    mem_out_type         out;
  } imem_ctrl_reg_type;

  localparam imem_ctrl_reg_type init_imem_ctrl_reg = '{
    state:  IDLE,
    cnt:    '0,
    pend:   P_NONE,
    ram_en: 1'b0,
    out:    '0
  };

  // A later abort must not demote a pending fence.
  function automatic pend_type merge_pend(
    input pend_type old,
    input pend_type nw
  );
    pend_type res;
    res = nw;
    if (nw == P_NONE)
      res = old;
    else if (old == P_FENCE && nw == P_ABORT)
      res = old;
    return res;
  endfunction

endpackage

// File: rtl/imem_ctrl_if.sv
// Fetch-side instruction port bundle.
// master = fetch stage, slave = memory responder.
interface imem_ctrl_if;
  import imem_ctrl_pkg::*;

  mem_in_type  mem_in;
  mem_out_type mem_out;

  modport master (output mem_in, input mem_out);
  modport slave  (input mem_in, output mem_out);

endinterface

// File: rtl/imem_line_buffer.sv
// Single-entry instruction line buffer.
// Combinational lookup; fill and invalidate are registered.
module imem_line_buffer #(
  parameter int AW = 14
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] lookup_addr,
  output logic          hit,
  output logic [31:0]   hit_data,
  input  logic          fill,
  input  logic [AW-1:0] fill_addr,
  input  logic [31:0]   fill_data,
  input  logic          inv
);

  logic          valid;
  logic [AW-1:0] tag;
  logic [31:0]   data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      tag   <= '0;
      data  <= '0;
    end else if (inv) begin
      valid <= 1'b0;
    end else if (fill) begin
      valid <= 1'b1;
      tag   <= fill_addr;
      data  <= fill_data;
    end
  end

  assign hit      = valid && (tag == lookup_addr);
  assign hit_data = data;

endmodule

// File: rtl/imem_ctrl.sv
// Instruction-memory responder: line buffer in front of
// a fixed-latency SRAM, one ready pulse per request.
module imem_ctrl
  import imem_ctrl_pkg::*;
#(
  parameter int          RAM_AW    = 14,
  parameter int          RAM_LAT   = 2,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic              clock,
  input  logic              reset,
  imem_ctrl_if.slave        fetch,
  output logic              ram_en,
  output logic [RAM_AW-1:0] ram_addr,
  input  logic [31:0]       ram_rdata
);

  imem_ctrl_reg_type r, v;
  mem_in_type        req;
  pend_type          in_kind, merged;
  logic [RAM_AW-1:0] raddr_q, raddr_d;
  logic [RAM_AW-1:0] paddr_q, paddr_d;
  logic [RAM_AW-1:0] in_word, lk_word;
  logic [31:0]       off, hit_data;
  logic              in_err, hit, fill;

  assign req     = fetch.mem_in;
  assign off     = req.addr - BASE_ADDR;
  assign in_word = off[RAM_AW+1:2];
  // Below-base addresses wrap to large offsets.
  assign in_err  = !req.instr || (req.wstrb != '0)
                || ((off >> (RAM_AW + 2)) != '0);

  always_comb begin
    in_kind = P_NONE;
    unique case (1'b1)
      req.valid:
        in_kind = in_err ? P_ERR : P_READ;
      !req.valid && req.fence:
        in_kind = P_FENCE;
      !req.valid && !req.fence && req.spec:
        in_kind = P_ABORT;
      default:
        in_kind = P_NONE;
    endcase
  end

  assign merged = merge_pend(r.pend, in_kind);

  always_comb begin
    lk_word = in_word;
    if (r.state == DRAIN && in_kind != P_READ
        && in_kind != P_ERR)
      lk_word = paddr_q;
  end

  imem_line_buffer #(.AW(RAM_AW)) u_lb (
    .clk        (clock),
    .rst_n      (reset),
    .lookup_addr(lk_word),
    .hit        (hit),
    .hit_data   (hit_data),
    .fill       (fill),
    .fill_addr  (raddr_q),
    .fill_data  (ram_rdata),
    .inv        (r.state == FLUSH)
  );

  always_comb begin
    pend_type kind;
    logic     go;
    v        = r;
    v.ram_en = 1'b0;
    v.out    = '0;
    raddr_d  = raddr_q;
    paddr_d  = paddr_q;
    fill     = 1'b0;
    go       = 1'b0;
    kind     = in_kind;
    unique case (r.state)
      IDLE: go = 1'b1;
      READ: begin
        if (in_kind != P_NONE) begin
          v.state = DRAIN;
          v.pend  = in_kind;
          paddr_d = in_word;
          if (r.cnt != '0)
            v.cnt = r.cnt - 1'b1;
        end else if (r.cnt == '0) begin
          v.state         = IDLE;
          v.out.mem_ready = 1'b1;
          v.out.mem_rdata = ram_rdata;
          fill            = 1'b1;
        end else begin
          v.cnt = r.cnt - 1'b1;
        end
      end
      DRAIN: begin
        v.pend  = merged;
        paddr_d = lk_word;
        if (r.cnt == '0) begin
          go   = 1'b1;
          kind = merged;
        end else begin
          v.cnt = r.cnt - 1'b1;
        end
      end
      FLUSH: begin
        v.state         = IDLE;
        v.out.mem_ready = 1'b1;
      end
    endcase
    if (go) begin
      v.pend  = P_NONE;
      v.state = IDLE;
      unique case (kind)
        P_READ: begin
          if (hit) begin
            v.out.mem_ready = 1'b1;
            v.out.mem_rdata = hit_data;
          end else begin
            v.state  = READ;
            v.ram_en = 1'b1;
            v.cnt    = CNT_W'(RAM_LAT);
            raddr_d  = lk_word;
          end
        end
        P_ERR: begin
          v.out.mem_ready = 1'b1;
          v.out.mem_error = 1'b1;
        end
        P_FENCE: v.state = FLUSH;
        P_ABORT: v.out.mem_ready = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r       <= init_imem_ctrl_reg;
      raddr_q <= '0;
      paddr_q <= '0;
    end else begin
      r       <= v;
      raddr_q <= raddr_d;
      paddr_q <= paddr_d;
    end
  end

  assign fetch.mem_out = r.out;
  assign ram_en        = r.ram_en;
  assign ram_addr      = raddr_q;

endmodule

// File: tb/tb_imem_ctrl.sv
// Randomized bench for imem_ctrl against a transaction-level
// model of the line buffer and the response latencies.
module tb_imem_ctrl;
  import imem_ctrl_pkg::*;

  localparam int          AW   = 14;
  localparam int          L    = 2;
  localparam logic [31:0] BASE = 32'h0;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          ram_en;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_rdata;

  imem_ctrl_if fetch_if();

  imem_ctrl #(.RAM_AW(AW), .RAM_LAT(L), .BASE_ADDR(BASE)) dut (
    .clock    (clock),
    .reset    (reset),
    .fetch    (fetch_if.slave),
    .ram_en   (ram_en),
    .ram_addr (ram_addr),
    .ram_rdata(ram_rdata)
  );

  always #5 clock = ~clock;

  logic [31:0] sram [0:(1<<AW)-1];
  logic [31:0] pipe [0:L-1];
  always @(posedge clock) begin
    pipe[0] <= sram[ram_addr];
    for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
  end
  assign ram_rdata = pipe[L-1];

  int cyc = 0;
  always @(posedge clock) cyc++;

  int            p_cyc[$];
  logic [31:0]   p_data[$];
  logic          p_err[$];
  int            en_cnt;
  logic [AW-1:0] en_addr;
  logic          dirty;

  always @(negedge clock) begin
    if (reset) begin
      if (fetch_if.mem_out.mem_ready) begin
        p_cyc.push_back(cyc + 1);
        p_data.push_back(fetch_if.mem_out.mem_rdata);
        p_err.push_back(fetch_if.mem_out.mem_error);
      end else if (fetch_if.mem_out.mem_rdata != 0
                   || fetch_if.mem_out.mem_error)
        dirty = 1'b1;
      if (ram_en) begin
        en_cnt++;
        en_addr = ram_addr;
      end
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model: the single cached word.
  logic          lb_valid;
  logic [AW-1:0] lb_tag;
  logic [31:0]   lb_data;

  function automatic logic [31:0] word_val(input logic [AW-1:0] w);
    if (w == AW'(32'h40)) return 32'hDEAD_BEEF;
    return (32'(w) * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  function automatic logic [AW-1:0] word_of(input logic [31:0] a);
    logic [31:0] o;
    o = (a - BASE) >> 2;
    return o[AW-1:0];
  endfunction

  // 0 = error, 1 = hit, 2 = miss
  function automatic int classify(input logic [31:0] a,
                                  input logic [3:0] ws,
                                  input logic ins);
    if (!ins || ws != 4'h0) return 0;
    if (a < BASE || (a - BASE) >= (32'd4 << AW)) return 0;
    if (lb_valid && lb_tag == word_of(a)) return 1;
    return 2;
  endfunction

  function automatic logic [31:0] rand_addr();
    logic [AW-1:0] w;
    case ($urandom_range(0, 7))
      0: w = 14'h0040;
      1: w = 14'h0080;
      2: w = 14'h00C0;
      3: w = 14'h00C1;
      4: w = 14'h0041;
      5: w = 14'h1000;
      6: w = 14'h3FFF;
      default: w = 14'h3FFE;
    endcase
    return BASE + (32'(w) << 2) + 32'($urandom_range(0, 3));
  endfunction

  task automatic drive_rd(input logic [31:0] a,
                          input logic [3:0] ws,
                          input logic ins);
    fetch_if.mem_in = '{valid: 1'b1, fence: 1'b0, spec: 1'b0,
                        instr: ins, addr: a, wstrb: ws};
  endtask

  task automatic drive_ctl(input logic f, input logic s);
    fetch_if.mem_in = '{valid: 1'b0, fence: f, spec: s,
                        instr: 1'b0, addr: 32'h0, wstrb: 4'h0};
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_mon();
    p_cyc.delete();
    p_data.delete();
    p_err.delete();
    en_cnt = 0;
    dirty  = 1'b0;
  endtask

  // kind: 0 read, 1 fence, 2 abort, 3 miss+abort,
  //       4 miss+read, 5 miss+fence
  task automatic do_op(input int kind,
                       input logic [31:0] a1,
                       input logic [3:0] ws1,
                       input logic ins1,
                       input logic [31:0] a2,
                       input logic [3:0] ws2,
                       input logic ins2);
    int            t, n, en_exp, c;
    logic [31:0]   d;
    logic          e, chk_addr;
    logic [AW-1:0] addr_exp;
    clear_mon();
    t = cyc + 1;
    case (kind)
      1:       drive_ctl(1'b1, 1'b0);
      2:       drive_ctl(1'b0, 1'b1);
      default: drive_rd(a1, ws1, ins1);
    endcase
    step();
    case (kind)
      3:       drive_ctl(1'b0, 1'b1);
      4:       drive_rd(a2, ws2, ins2);
      5:       drive_ctl(1'b1, 1'b0);
      default: drive_ctl(1'b0, 1'b0);
    endcase
    if (kind >= 3) step();
    drive_ctl(1'b0, 1'b0);
    repeat (2 * L + 8) step();
    d = 32'h0; e = 1'b0; en_exp = 0; n = 1;
    chk_addr = 1'b0; addr_exp = word_of(a1);
    case (kind)
      0: begin
        c = classify(a1, ws1, ins1);
        if (c == 0) e = 1'b1;
        else if (c == 1) d = lb_data;
        else begin
          n = L + 2; d = word_val(word_of(a1));
          en_exp = 1; chk_addr = 1'b1;
          lb_valid = 1'b1; lb_tag = word_of(a1); lb_data = d;
        end
      end
      1: begin n = 2; lb_valid = 1'b0; end
      2: n = 1;
      3: begin n = L + 2; en_exp = 1; chk_addr = 1'b1; end
      4: begin
        c = classify(a2, ws2, ins2);
        n = L + 2; en_exp = 1; chk_addr = 1'b1;
        if (c == 0) e = 1'b1;
        else if (c == 1) d = lb_data;
        else begin
          n = 2 * L + 3; d = word_val(word_of(a2));
          en_exp = 2; addr_exp = word_of(a2);
          lb_valid = 1'b1; lb_tag = word_of(a2); lb_data = d;
        end
      end
      default: begin
        n = L + 3; en_exp = 1; chk_addr = 1'b1;
        lb_valid = 1'b0;
      end
    endcase
    chk("pulses", p_cyc.size(), 1);
    if (p_cyc.size() > 0) begin
      chk("latency", p_cyc[0] - t, n);
      chk("rdata", p_data[0], d);
      chk("error", 32'(p_err[0]), 32'(e));
    end
    chk("ram_en", en_cnt, en_exp);
    if (chk_addr) chk("ram_addr", 32'(en_addr), 32'(addr_exp));
    chk("idle_zero", 32'(dirty), 0);
  endtask

  task automatic chk_outs_zero(input string tag);
    chk({tag, "_ready"}, 32'(fetch_if.mem_out.mem_ready), 0);
    chk({tag, "_rdata"}, fetch_if.mem_out.mem_rdata, 0);
    chk({tag, "_error"}, 32'(fetch_if.mem_out.mem_error), 0);
    chk({tag, "_ram_en"}, 32'(ram_en), 0);
    chk({tag, "_ram_addr"}, 32'(ram_addr), 0);
  endtask

  initial begin
    logic [31:0] a1, a2;
    logic [3:0]  ws1, ws2;
    logic        in1, in2;
    int          k, r;
    drive_ctl(1'b0, 1'b0);
    for (int i = 0; i < (1 << AW); i++) sram[i] = word_val(AW'(i));
    lb_valid = 1'b0; lb_tag = '0; lb_data = '0;
    clear_mon();
    repeat (3) step();
    chk_outs_zero("reset");
    reset = 1'b1;
    step();
    chk_outs_zero("post_rst");

    do_op(0, 32'h100, 4'h0, 1'b1, 32'h0, 4'h0, 1'b1);
    do_op(0, 32'h100, 4'h0, 1'b1, 32'h0, 4'h0, 1'b1);
    do_op(0, 32'h102, 4'h0, 1'b1, 32'h0, 4'h0, 1'b1);
    do_op(0, BASE + (32'd4 << AW), 4'h0, 1'b1, 32'h0, 4'h0, 1'b1);
    do_op(0, 32'h104, 4'hF, 1'b1, 32'h0, 4'h0, 1'b1);
    do_op(3, 32'h200, 4'h0, 1'b1, 32'h0, 4'h0, 1'b1);
    do_op(0, 32'h200, 4'h0, 1'b1, 32'h0, 4'h0, 1'b1);
    do_op(0, 32'h100, 4'h0, 1'b1, 32'h0, 4'h0, 1'b1);
    do_op(1, 32'h0, 4'h0, 1'b1, 32'h0, 4'h0, 1'b1);
    do_op(0, 32'h100, 4'h0, 1'b1, 32'h0, 4'h0, 1'b1);
    do_op(4, 32'h300, 4'h0, 1'b1, 32'h304, 4'h0, 1'b1);

    for (int i = 0; i < 80; i++) begin
      k = $urandom_range(0, 5);
      a1 = rand_addr(); ws1 = 4'h0; in1 = 1'b1;
      a2 = rand_addr(); ws2 = 4'h0; in2 = 1'b1;
      if (k == 0) begin
        r = $urandom_range(0, 9);
        if (r == 0) a1 = BASE + (32'd4 << AW) + 32'($urandom_range(0, 15) * 4);
        if (r == 1) ws1 = 4'($urandom_range(1, 15));
        if (r == 2) in1 = 1'b0;
      end
      r = $urandom_range(0, 9);
      if (r == 0) a2 = BASE + (32'd4 << AW);
      if (r == 1) ws2 = 4'($urandom_range(1, 15));
      if (r == 2) in2 = 1'b0;
      if (k >= 3 && lb_valid && word_of(a1) == lb_tag)
        a1 = a1 ^ 32'h8;
      do_op(k, a1, ws1, in1, a2, ws2, in2);
    end

    clear_mon();
    drive_rd(32'h400, 4'h0, 1'b1);
    step();
    drive_ctl(1'b0, 1'b0);
    step();
    reset = 1'b0;
    #1;
    chk_outs_zero("mid_rst");
    step();
    step();
    reset = 1'b1;
    clear_mon();
    repeat (10) step();
    chk("post_rst_pulses", p_cyc.size(), 0);
    chk("post_rst_ram_en", en_cnt, 0);
    lb_valid = 1'b0;
    do_op(0, 32'h100, 4'h0, 1'b1, 32'h0, 4'h0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
